// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked SPRAM main memory.
package mem_pkg;

  localparam int SPRAM_AW = 14;
  localparam int SPRAM_DW = 16;

  typedef enum logic {BANK_ACTIVE = 1'b0, BANK_STANDBY = 1'b1} bank_state_e;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  function automatic logic [3:0] be_to_mask(input logic [1:0] be);
    return {be[1], be[1], be[0], be[0]};
  endfunction

endpackage

// File: rtl/spram_bank.sv
// One 16K x 16 single-port SPRAM bank (nibble write masks, registered DATAOUT)
// together with its idle-driven ACTIVE/STANDBY power state machine.
module spram_bank
  import mem_pkg::*;
#(
  parameter int IDLE_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                grant_i,
  input  logic                wren_i,
  input  logic [SPRAM_AW-1:0] addr_i,
  input  logic [SPRAM_DW-1:0] wdata_i,
  input  logic [3:0]          mask_i,
  output logic [SPRAM_DW-1:0] dataout_o,
  output logic                standby_o
);

  localparam int CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);

  bank_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                chipselect_s;
  logic                write_s;
  logic [SPRAM_DW-1:0] mem_q [0:(1 << SPRAM_AW) - 1];
  logic [SPRAM_DW-1:0] dataout_q;

  // A grant always means the bank is in use, so a request arriving on the
  // standby-entry cycle keeps the bank awake with no penalty.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BANK_ACTIVE: begin
        if (grant_i || (IDLE_CYCLES == 0)) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = BANK_STANDBY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BANK_STANDBY: begin
        if (req_i) begin
          state_d = BANK_ACTIVE;
        end else begin
          state_d = BANK_STANDBY;
        end
        cnt_d = '0;
      end
      default: begin
        state_d = BANK_ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BANK_ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign chipselect_s = grant_i && (state_q == BANK_ACTIVE);
  assign write_s      = chipselect_s && wren_i;
  assign standby_o    = (state_q == BANK_STANDBY);

  always_ff @(posedge clk_i) begin
    if (write_s) begin
      for (int n = 0; n < 4; n++) begin
        if (mask_i[n]) begin
          mem_q[addr_i][4*n +: 4] <= wdata_i[4*n +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dataout_q <= '0;
    end else if (chipselect_s && !wren_i) begin
      dataout_q <= mem_q[addr_i];
    end
  end

  assign dataout_o = dataout_q;

endmodule

// File: rtl/banked_spram_mem.sv
// Dual-requester banked SPRAM memory: per-cycle bank arbitration with a
// round-robin pointer on conflict, and per-port registered read return.
module banked_spram_mem
  import mem_pkg::*;
#(
  parameter int BITS        = 16,
  parameter int BANK_BITS   = 2,
  parameter int IDLE_CYCLES = 64
) (
  input  logic                        CLK,
  input  logic                        RSTb,
  input  logic                        A_VALID,
  output logic                        A_READY,
  input  logic                        A_WR,
  input  logic [SPRAM_AW+BANK_BITS-1:0] A_ADDR,
  input  logic [BITS-1:0]             A_WDATA,
  input  logic [1:0]                  A_BE,
  output logic                        A_RVALID,
  output logic [BITS-1:0]             A_RDATA,
  input  logic                        B_VALID,
  output logic                        B_READY,
  input  logic                        B_WR,
  input  logic [SPRAM_AW+BANK_BITS-1:0] B_ADDR,
  input  logic [BITS-1:0]             B_WDATA,
  input  logic [1:0]                  B_BE,
  output logic                        B_RVALID,
  output logic [BITS-1:0]             B_RDATA
);

  localparam int NB = 1 << BANK_BITS;
  localparam int AW = SPRAM_AW + BANK_BITS;

  logic [BANK_BITS-1:0] bank_a_s, bank_b_s;
  logic [NB-1:0]        standby_s;
  logic [BITS-1:0]      dout_s [NB];
  logic                 a_ok_s, b_ok_s, conflict_s, grant_a_s, grant_b_s;
  port_e                rr_q, rr_d;
  logic                 a_rvalid_q, b_rvalid_q;
  logic [BANK_BITS-1:0] a_idx_q, b_idx_q;
  logic [BITS-1:0]      a_rdata_q, b_rdata_q;

  assign bank_a_s = A_ADDR[AW-1:SPRAM_AW];
  assign bank_b_s = B_ADDR[AW-1:SPRAM_AW];

  // Gating with RSTb keeps every chip-select and write-enable low during reset.
  always_comb begin
    a_ok_s     = A_VALID && RSTb && !standby_s[bank_a_s];
    b_ok_s     = B_VALID && RSTb && !standby_s[bank_b_s];
    conflict_s = a_ok_s && b_ok_s && (bank_a_s == bank_b_s);
    grant_a_s  = a_ok_s && (!conflict_s || (rr_q == PORT_A));
    grant_b_s  = b_ok_s && (!conflict_s || (rr_q == PORT_B));
    rr_d       = conflict_s ? ((rr_q == PORT_A) ? PORT_B : PORT_A) : rr_q;
  end

  assign A_READY = grant_a_s;
  assign B_READY = grant_b_s;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic                sel_a_s, sel_b_s, req_s, grant_s, wren_s;
    logic [SPRAM_AW-1:0] addr_s;
    logic [BITS-1:0]     wdata_s;
    logic [3:0]          mask_s;

    assign sel_a_s = grant_a_s && (bank_a_s == BANK_BITS'(b));
    assign sel_b_s = grant_b_s && (bank_b_s == BANK_BITS'(b));
    assign grant_s = sel_a_s || sel_b_s;
    assign req_s   = (A_VALID && (bank_a_s == BANK_BITS'(b))) ||
                     (B_VALID && (bank_b_s == BANK_BITS'(b)));
    assign wren_s  = sel_b_s ? B_WR : A_WR;
    assign addr_s  = sel_b_s ? B_ADDR[SPRAM_AW-1:0] : A_ADDR[SPRAM_AW-1:0];
    assign wdata_s = sel_b_s ? B_WDATA : A_WDATA;
    assign mask_s  = be_to_mask(sel_b_s ? B_BE : A_BE);

    spram_bank #(
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_bank (
      .clk_i    (CLK),
      .rst_ni   (RSTb),
      .req_i    (req_s),
      .grant_i  (grant_s),
      .wren_i   (wren_s),
      .addr_i   (addr_s),
      .wdata_i  (wdata_s),
      .mask_i   (mask_s),
      .dataout_o(dout_s[b]),
      .standby_o(standby_s[b])
    );
  end

  // Read return: the bank index is captured at grant so the data mux never
  // follows a requester's next (live) address.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rr_q       <= PORT_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_idx_q    <= '0;
      b_idx_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      a_rvalid_q <= grant_a_s && !A_WR;
      b_rvalid_q <= grant_b_s && !B_WR;
      if (grant_a_s && !A_WR) a_idx_q <= bank_a_s;
      if (grant_b_s && !B_WR) b_idx_q <= bank_b_s;
      if (a_rvalid_q) a_rdata_q <= dout_s[a_idx_q];
      if (b_rvalid_q) b_rdata_q <= dout_s[b_idx_q];
    end
  end

  assign A_RVALID = a_rvalid_q;
  assign B_RVALID = b_rvalid_q;
  assign A_RDATA  = a_rvalid_q ? dout_s[a_idx_q] : a_rdata_q;
  assign B_RDATA  = b_rvalid_q ? dout_s[b_idx_q] : b_rdata_q;

endmodule
